muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It sits beside the register file: its operands come from the register-file read ports (rs, rt), and its HI/LO outputs feed the write-data mux back into the register file for MFHI/MFLO. It executes MULT, MULTU, DIV and DIVU over 33 cycles, using a shift-add multiplier and a restoring divider. The controller stalls the PC while `busy` is high.

---
 rtl/muldiv_unit_if.sv | 21 ++
 rtl/muldiv_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: bundle between the core controller and the multiply/divide unit.
//   master (core) : start, op, a, b, mthi, mtlo, wdata
//   slave  (unit) : busy, done, hi, lo
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;     // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [31:0] a;      // rs: multiplicand / dividend
  logic [31:0] b;      // rt: multiplier / divisor
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, mthi, mtlo, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide with architectural HI/LO.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; abandons any operation in flight
//   bus   : muldiv_unit_if.slave (start/op/a/b, MTHI/MTLO, busy/done/hi/lo)
// An operation takes 33 cycles: 32 RUN iterations (shift-add multiply or
// restoring divide on magnitudes) plus one FIX cycle that applies signs
// and writes HI/LO. done pulses in the cycle after FIX.
module muldiv_unit (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_neg;    // result sign: sign(a) ^ sign(b), signed ops only
  logic        r_sgna;   // dividend sign, for the remainder
  logic        r_dz;     // divisor was zero
  logic [31:0] r_opnd;   // multiplicand (mul) or divisor (div)
  logic [31:0] r_aorig;  // raw a, returned as HI on divide by zero
  logic [63:0] r_acc;    // product (mul) or {rem, quot} (div)
  logic [31:0] r_hi, r_lo;
  logic        r_done;

  // Operand magnitudes; op[0]==0 selects the signed variants.
  logic        w_signed;
  logic [31:0] w_abs_a, w_abs_b;
  assign w_signed = ~bus.op[0];
  assign w_abs_a  = (w_signed && bus.a[31]) ? -bus.a : bus.a;
  assign w_abs_b  = (w_signed && bus.b[31]) ? -bus.b : bus.b;

  // Multiply step: conditional add into the upper half, carry kept as
  // the new MSB after the right shift.
  logic [32:0] w_msum;
  assign w_msum = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};

  // Divide step: shifted remainder is 33 bits wide; when it is >= the
  // divisor the difference is known to fit in 32 bits.
  logic        w_dge;
  logic [31:0] w_ddiff;
  assign w_dge   = (r_acc[63:31] >= {1'b0, r_opnd});
  assign w_ddiff = r_acc[62:31] - r_opnd;

  logic [63:0] w_iter;
  always_comb begin
    w_iter = r_acc;
    if (r_op[1]) begin
      if (w_dge) w_iter = {w_ddiff, r_acc[30:0], 1'b1};
      else       w_iter = {r_acc[62:0], 1'b0};
    end else begin
      if (r_acc[0]) w_iter = {w_msum, r_acc[31:1]};
      else          w_iter = {1'b0, r_acc[63:1]};
    end
  end

  // Sign fix-up applied in FIX.
  logic [63:0] w_prod;
  logic [31:0] w_quot, w_rem;
  assign w_prod = (r_op == 2'b00 && r_neg)  ? -r_acc         : r_acc;
  assign w_quot = (r_op == 2'b10 && r_neg)  ? -r_acc[31:0]   : r_acc[31:0];
  assign w_rem  = (r_op == 2'b10 && r_sgna) ? -r_acc[63:32]  : r_acc[63:32];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_sgna  <= 1'b0;
      r_dz    <= 1'b0;
      r_opnd  <= '0;
      r_aorig <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.mthi) r_hi <= bus.wdata;
          if (bus.mtlo) r_lo <= bus.wdata;
          if (bus.start) begin
            r_op    <= bus.op;
            r_neg   <= w_signed & (bus.a[31] ^ bus.b[31]);
            r_sgna  <= w_signed & bus.a[31];
            r_dz    <= (bus.b == 32'd0);
            r_aorig <= bus.a;
            r_opnd  <= bus.op[1] ? w_abs_b : w_abs_a;
            r_acc   <= {32'd0, bus.op[1] ? w_abs_a : w_abs_b};
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_iter;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          if (!r_op[1]) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end else if (r_dz) begin
            r_hi <= r_aorig;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
